dmem_responder: RTL and testbench

//   Data-memory responder for the core's load/store port: the target end of the

---
 rtl/dmem_responder.sv | 154 +++++++++++++++
 tb/tb_dmem_responder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder
//   Target end of the core's valid/ready data-memory port. It holds a
//   word-organised RAM and accepts one request at a time. After LATENCY wait
//   states it returns load data, or a write acknowledge, together with an
//   error flag.
// Ports
//   clk, rst        clock (rising edge) and asynchronous active-high reset
//   req_valid/ready request handshake
//   req_we          1 = store, 0 = load
//   req_addr        byte address (must be word aligned and inside the RAM)
//   req_wdata/wstrb store data and byte enables (bit n -> wdata[8n+7:8n])
//   resp_valid/ready response handshake
//   resp_rdata      load data (0 for stores and errors)
//   resp_err        misaligned or out-of-range access
module dmem_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  // Last counter value spent in WAIT; unused when LATENCY is 0.
  localparam logic [3:0] CNT_LAST = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  wait_cnt;
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_wstrb;
  logic        resp_load;

  logic [31:0] mem [DEPTH];
  logic [31:0] ram_q;

  logic        accept;
  logic        enter_resp;
  logic        cur_we;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic [3:0]  cur_wstrb;
  logic        cur_err;
  logic [DEPTH_LOG2-1:0] cur_idx;

  // req_ready is a registered output: it is cleared by reset and by the
  // accept itself, so no accept can happen while rst is high.
  assign accept = req_valid & req_ready;

  // The transaction that commits on the edge entering RESP. With no wait
  // states that edge is the accept edge, so the live request is used.
  generate
    if (LATENCY == 0) begin : g_direct
      assign cur_we    = req_we;
      assign cur_addr  = req_addr;
      assign cur_wdata = req_wdata;
      assign cur_wstrb = req_wstrb;
      assign enter_resp = accept;
    end else begin : g_latched
      assign cur_we    = lat_we;
      assign cur_addr  = lat_addr;
      assign cur_wdata = lat_wdata;
      assign cur_wstrb = lat_wstrb;
      assign enter_resp = (state == WAIT) && (wait_cnt == CNT_LAST);
    end
  endgenerate

  assign cur_err = (|cur_addr[1:0]) | (|cur_addr[31:DEPTH_LOG2+2]);
  assign cur_idx = cur_addr[DEPTH_LOG2+1:2];

  // RAM: byte-lane write and registered read, both on the edge entering
  // RESP. No reset, so contents survive rst; a store still in WAIT never
  // reaches this edge when rst interrupts it.
  always_ff @(posedge clk) begin
    if (enter_resp && !cur_err) begin
      if (cur_we) begin
        for (int b = 0; b < 4; b++) begin
          if (cur_wstrb[b]) mem[cur_idx][8*b +: 8] <= cur_wdata[8*b +: 8];
        end
      end else begin
        ram_q <= mem[cur_idx];
      end
    end
  end

  // ram_q only changes on the edge entering RESP, so this is stable while
  // the response is stalled.
  assign resp_rdata = resp_load ? ram_q : 32'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wait_cnt   <= 4'd0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_load  <= 1'b0;
      lat_we     <= 1'b0;
      lat_addr   <= 32'd0;
      lat_wdata  <= 32'd0;
      lat_wstrb  <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (accept) begin
            req_ready <= 1'b0;
            lat_we    <= req_we;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_wstrb <= req_wstrb;
            wait_cnt  <= 4'd0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt + 4'd1;
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_load  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      // Common entry into RESP, from WAIT or straight from an accept.
      if (enter_resp) begin
        state      <= RESP;
        resp_valid <= 1'b1;
        resp_err   <= cur_err;
        resp_load  <= ~cur_we & ~cur_err;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  always #5 clk = ~clk;

  // LATENCY=2 instance
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;

  // LATENCY=0 instance
  logic        f_req_valid, f_req_ready, f_req_we;
  logic [31:0] f_req_addr, f_req_wdata;
  logic [3:0]  f_req_wstrb;
  logic        f_resp_valid, f_resp_ready, f_resp_err;
  logic [31:0] f_resp_rdata;

  dmem_responder #(.DEPTH_LOG2(10), .LATENCY(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  dmem_responder #(.DEPTH_LOG2(10), .LATENCY(0)) dut_fast (
    .clk(clk), .rst(rst),
    .req_valid(f_req_valid), .req_ready(f_req_ready), .req_we(f_req_we),
    .req_addr(f_req_addr), .req_wdata(f_req_wdata), .req_wstrb(f_req_wstrb),
    .resp_valid(f_resp_valid), .resp_ready(f_resp_ready),
    .resp_rdata(f_resp_rdata), .resp_err(f_resp_err)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One transaction on the LATENCY=2 instance with resp_ready=1. Called and
  // returns 1 time unit after a rising edge. edges counts the accept edge as 1.
  task automatic xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, output logic [31:0] rdata,
                      output logic err, output int edges);
    int n;
    n = 0;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = strb;
    @(posedge clk); #1;
    // garbage after accept must be ignored
    req_valid = 1'b0; req_we = ~we; req_addr = $urandom; req_wdata = $urandom; req_wstrb = 4'hF;
    edges = 1;
    while (!resp_valid && edges < 40) begin @(posedge clk); #1; edges++; end
    rdata = resp_rdata;
    err   = resp_err;
    $display("xfer we=%0d addr=%h wdata=%h strb=%h -> rdata=%h err=%0d edges=%0d",
             we, addr, wdata, strb, rdata, err, edges);
    @(posedge clk); #1;
  endtask

  logic [31:0] rd;
  logic        er;
  int          ed;

  // fast-instance stream: we, addr, wdata, expected rdata, expected err
  logic        f_we  [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [31:0] f_ad  [5] = '{32'h4, 32'h8, 32'h4, 32'h8, 32'h6};
  logic [31:0] f_wd  [5] = '{32'hA5A5A5A5, 32'h0BADF00D, 32'h0, 32'h0, 32'h0};
  logic [31:0] f_erd [5] = '{32'h0, 32'h0, 32'hA5A5A5A5, 32'h0BADF00D, 32'h0};
  logic        f_eer [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0; resp_ready = 1;
    f_req_valid = 0; f_req_we = 0; f_req_addr = 0; f_req_wdata = 0; f_req_wstrb = 0;
    f_resp_ready = 1;

    // asynchronous reset, checked before any clock edge
    #2 rst = 1'b1;
    #2;
    check("rst_req_ready", req_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_resp_err", resp_err, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("idle_req_ready", req_ready, 1);

    // preload
    xfer(1, 32'h20, 32'h11111111, 4'hF, rd, er, ed);
    xfer(1, 32'h0, 32'h12345678, 4'hF, rd, er, ed);

    // full-word store then load, latency
    xfer(1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, ed);
    check("st_edges", ed, 3);
    check("st_rdata", rd, 0);
    check("st_err", er, 0);
    xfer(0, 32'h10, 32'h0, 4'h0, rd, er, ed);
    check("ld_edges", ed, 3);
    check("ld_rdata", rd, 32'hDEADBEEF);
    check("ld_err", er, 0);

    // byte strobes
    xfer(1, 32'h10, 32'h000000AA, 4'h1, rd, er, ed);
    xfer(0, 32'h10, 32'h0, 4'hF, rd, er, ed);
    check("strb1_rdata", rd, 32'hDEADBEAA);
    xfer(1, 32'h10, 32'hFFFFFFFF, 4'h0, rd, er, ed);
    check("strb0_err", er, 0);
    xfer(0, 32'h10, 32'h0, 4'h0, rd, er, ed);
    check("strb0_rdata", rd, 32'hDEADBEAA);
    xfer(1, 32'h10, 32'hAABBCCDD, 4'hC, rd, er, ed);
    xfer(0, 32'h10, 32'h0, 4'h0, rd, er, ed);
    check("strbC_rdata", rd, 32'hAABBBEAA);

    // errors
    xfer(0, 32'h12, 32'h0, 4'h0, rd, er, ed);
    check("misal_err", er, 1);
    check("misal_rdata", rd, 0);
    xfer(1, 32'h1000, 32'hCAFEF00D, 4'hF, rd, er, ed);
    check("oor_err", er, 1);
    xfer(0, 32'h0, 32'h0, 4'h0, rd, er, ed);
    check("oor_nowrite", rd, 32'h12345678);
    check("oor_nowrite_err", er, 0);

    // response stall
    resp_ready = 1'b0;
    req_valid = 1; req_we = 0; req_addr = 32'h10;
    @(posedge clk); #1;
    req_valid = 0; req_addr = 32'h0;
    n = 0;
    while (!resp_valid && n < 40) begin @(posedge clk); #1; n++; end
    for (int i = 0; i < 5; i++) begin
      req_addr = $urandom; req_we = 1'b1; req_valid = 1'b1;
      check("stall_valid", resp_valid, 1);
      check("stall_rdata", resp_rdata, 32'hAABBBEAA);
      check("stall_err", resp_err, 0);
      check("stall_req_ready", req_ready, 0);
      $display("stall cycle %0d rdata=%h", i, resp_rdata);
      @(posedge clk); #1;
    end
    req_valid = 1'b0; req_we = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    check("release_valid", resp_valid, 0);
    check("release_req_ready", req_ready, 1);

    // reset during WAIT of a store drops it
    req_valid = 1; req_we = 1; req_addr = 32'h20; req_wdata = 32'h55555555; req_wstrb = 4'hF;
    @(posedge clk); #1;
    req_valid = 0;
    check("wait_valid", resp_valid, 0);
    #1 rst = 1'b1;
    #1;
    check("midrst_req_ready", req_ready, 0);
    check("midrst_valid", resp_valid, 0);
    check("midrst_rdata", resp_rdata, 0);
    check("midrst_err", resp_err, 0);
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    xfer(0, 32'h20, 32'h0, 4'h0, rd, er, ed);
    check("dropped_store", rd, 32'h11111111);

    // reset during RESP of a store keeps it
    resp_ready = 1'b0;
    req_valid = 1; req_we = 1; req_addr = 32'h24; req_wdata = 32'h00000077; req_wstrb = 4'hF;
    @(posedge clk); #1;
    req_valid = 0;
    n = 0;
    while (!resp_valid && n < 40) begin @(posedge clk); #1; n++; end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk) begin rst = 1'b0; resp_ready = 1'b1; end
    @(posedge clk); #1;
    xfer(0, 32'h24, 32'h0, 4'h0, rd, er, ed);
    check("committed_store", rd, 32'h00000077);

    // LATENCY=0: back-to-back stream, one transaction per 2 cycles
    check("fast_idle_ready", f_req_ready, 1);
    f_req_valid = 1; f_req_we = f_we[0]; f_req_addr = f_ad[0];
    f_req_wdata = f_wd[0]; f_req_wstrb = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      $display("fast op %0d we=%0d addr=%h -> valid=%0d rdata=%h err=%0d",
               i, f_we[i], f_ad[i], f_resp_valid, f_resp_rdata, f_resp_err);
      check("fast_valid", f_resp_valid, 1);
      check("fast_rdata", f_resp_rdata, f_erd[i]);
      check("fast_err", f_resp_err, f_eer[i]);
      check("fast_busy", f_req_ready, 0);
      @(posedge clk); #1;
      check("fast_done", f_resp_valid, 0);
      check("fast_ready", f_req_ready, 1);
      if (i < 4) begin
        f_req_we = f_we[i+1]; f_req_addr = f_ad[i+1]; f_req_wdata = f_wd[i+1];
      end else begin
        f_req_valid = 0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
